// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder (one full-adder cell, LSB first) with start/busy/done handshake
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sa, sb, acc, acc_n;
    logic [CW-1:0] cnt;
    logic c, s, c_n, last, accept;
    always_comb begin
        s = sa[0] ^ sb[0] ^ c;
        c_n = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        acc_n = WIDTH'({s, acc} >> 1);
        last = cnt == LAST;
        accept = start && state != RUN;
        state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    // result reg fills from the MSB so it is aligned after exactly WIDTH shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
            acc <= '0;
            c <= 1'b0;
            cnt <= '0;
            sum <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            sa <= a;
            sb <= b;
            acc <= '0;
            c <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            acc <= acc_n;
            c <= c_n;
            cnt <= cnt + CW'(1);
            if (last) begin
                sum <= acc_n;
                cout <= c_n;
            end
        end
    end
endmodule
